// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared pipeline definitions for the EX/MEM register and branch-redirect logic.
package ex_mem_branch_stage_pkg;

    // State of the EX/MEM stage sequencer.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } stage_state_t;

    // funct3 codes for the branch conditions this stage resolves.
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/ex_mem_branch_stage_branch_cond.sv
// Combinational branch resolution from the ALU zero flag and funct3.
module branch_cond
    import ex_mem_branch_stage_pkg::*;
(
    input  logic       i_valid,
    input  logic       i_branch,
    input  logic       i_zero,
    input  logic [2:0] i_funct3,
    output logic       o_taken
);

    logic w_cond;

    // Only BEQ and BNE are resolved here; other codes never redirect.
    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  w_cond = i_zero;
            F3_BNE:  w_cond = ~i_zero;
            default: w_cond = 1'b0;
        endcase
        o_taken = i_valid & i_branch & w_cond;
    end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch redirect, flush generation and a
// taken-branch counter.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | normal capture; a taken branch arms a redirect
// ST_REDIRECT | pc_src asserted; the instruction now in EX is a wrong-path
//             | instruction and is captured as a bubble
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_ALUOut,
    input  logic [WIDTH-1:0] ex_immAddress,
    input  logic [WIDTH-1:0] ex_rd2,
    input  logic             ex_zero,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic             ex_MemWrite,
    input  logic             ex_MemtoReg,
    input  logic             ex_Branch,
    input  logic [2:0]       ex_funct3,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_ALUOut,
    output logic [WIDTH-1:0] mem_rd2,
    output logic [4:0]       mem_rd,
    output logic             mem_RegWrite,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             mem_MemtoReg,
    output logic             pc_src,
    output logic [WIDTH-1:0] branch_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [31:0]      taken_count
);

    stage_state_t     r_state, w_state_nxt;
    logic             r_mem_valid, w_mem_valid_nxt;
    logic [WIDTH-1:0] r_mem_ALUOut, w_mem_ALUOut_nxt;
    logic [WIDTH-1:0] r_mem_rd2, w_mem_rd2_nxt;
    logic [4:0]       r_mem_rd, w_mem_rd_nxt;
    logic             r_mem_RegWrite, w_mem_RegWrite_nxt;
    logic             r_mem_MemRead, w_mem_MemRead_nxt;
    logic             r_mem_MemWrite, w_mem_MemWrite_nxt;
    logic             r_mem_MemtoReg, w_mem_MemtoReg_nxt;
    logic             r_pc_src, w_pc_src_nxt;
    logic [WIDTH-1:0] r_branch_target, w_branch_target_nxt;
    logic [31:0]      r_taken_count, w_taken_count_nxt;
    logic             w_taken;

    branch_cond u_branch_cond (
        .i_valid  (ex_valid),
        .i_branch (ex_Branch),
        .i_zero   (ex_zero),
        .i_funct3 (ex_funct3),
        .o_taken  (w_taken)
    );

    // State and pipeline registers; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_mem_valid     <= 1'b0;
            r_mem_ALUOut    <= '0;
            r_mem_rd2       <= '0;
            r_mem_rd        <= '0;
            r_mem_RegWrite  <= 1'b0;
            r_mem_MemRead   <= 1'b0;
            r_mem_MemWrite  <= 1'b0;
            r_mem_MemtoReg  <= 1'b0;
            r_pc_src        <= 1'b0;
            r_branch_target <= '0;
            r_taken_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_mem_valid     <= w_mem_valid_nxt;
            r_mem_ALUOut    <= w_mem_ALUOut_nxt;
            r_mem_rd2       <= w_mem_rd2_nxt;
            r_mem_rd        <= w_mem_rd_nxt;
            r_mem_RegWrite  <= w_mem_RegWrite_nxt;
            r_mem_MemRead   <= w_mem_MemRead_nxt;
            r_mem_MemWrite  <= w_mem_MemWrite_nxt;
            r_mem_MemtoReg  <= w_mem_MemtoReg_nxt;
            r_pc_src        <= w_pc_src_nxt;
            r_branch_target <= w_branch_target_nxt;
            r_taken_count   <= w_taken_count_nxt;
        end
    end

    // Next-state and capture logic; everything holds while stalled.
    always_comb begin
        w_state_nxt         = r_state;
        w_mem_valid_nxt     = r_mem_valid;
        w_mem_ALUOut_nxt    = r_mem_ALUOut;
        w_mem_rd2_nxt       = r_mem_rd2;
        w_mem_rd_nxt        = r_mem_rd;
        w_mem_RegWrite_nxt  = r_mem_RegWrite;
        w_mem_MemRead_nxt   = r_mem_MemRead;
        w_mem_MemWrite_nxt  = r_mem_MemWrite;
        w_mem_MemtoReg_nxt  = r_mem_MemtoReg;
        w_pc_src_nxt        = r_pc_src;
        w_branch_target_nxt = r_branch_target;
        w_taken_count_nxt   = r_taken_count;

        if (!stall) begin
            w_mem_ALUOut_nxt   = ex_ALUOut;
            w_mem_rd2_nxt      = ex_rd2;
            w_mem_rd_nxt       = ex_rd;
            w_mem_MemtoReg_nxt = ex_MemtoReg;
            case (r_state)
                ST_IDLE: begin
                    w_mem_valid_nxt    = ex_valid;
                    w_mem_RegWrite_nxt = ex_RegWrite & ex_valid;
                    w_mem_MemRead_nxt  = ex_MemRead & ex_valid;
                    w_mem_MemWrite_nxt = ex_MemWrite & ex_valid;
                    w_pc_src_nxt       = 1'b0;
                    if (w_taken) begin
                        w_state_nxt         = ST_REDIRECT;
                        w_pc_src_nxt        = 1'b1;
                        w_branch_target_nxt = ex_immAddress;
                        w_taken_count_nxt   = r_taken_count + 32'd1;
                    end
                end
                ST_REDIRECT: begin
                    // Wrong-path instruction: keep its data, kill its side effects.
                    // A branch here is also wrong-path, so it never redirects.
                    w_mem_valid_nxt    = 1'b0;
                    w_mem_RegWrite_nxt = 1'b0;
                    w_mem_MemRead_nxt  = 1'b0;
                    w_mem_MemWrite_nxt = 1'b0;
                    w_pc_src_nxt       = 1'b0;
                    w_state_nxt        = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign mem_valid     = r_mem_valid;
    assign mem_ALUOut    = r_mem_ALUOut;
    assign mem_rd2       = r_mem_rd2;
    assign mem_rd        = r_mem_rd;
    assign mem_RegWrite  = r_mem_RegWrite;
    assign mem_MemRead   = r_mem_MemRead;
    assign mem_MemWrite  = r_mem_MemWrite;
    assign mem_MemtoReg  = r_mem_MemtoReg;
    assign pc_src        = r_pc_src;
    assign branch_target = r_branch_target;
    assign taken_count   = r_taken_count;
    assign flush_if_id   = r_pc_src;
    assign flush_id_ex   = r_pc_src;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Scoreboard bench for ex_mem_branch_stage: a reference model predicts the
// registered outputs for every driven cycle; predictions are queued and
// compared after the following rising edge.
module tb_ex_mem_branch_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, stall, ex_valid, ex_zero;
    logic [W-1:0]  ex_ALUOut, ex_immAddress, ex_rd2;
    logic [4:0]    ex_rd;
    logic          ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch;
    logic [2:0]    ex_funct3;
    logic          mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg;
    logic [W-1:0]  mem_ALUOut, mem_rd2, branch_target;
    logic [4:0]    mem_rd;
    logic          pc_src, flush_if_id, flush_id_ex;
    logic [31:0]   taken_count;

    always #5 clk = ~clk;

    ex_mem_branch_stage #(.WIDTH(W)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_ALUOut     (ex_ALUOut),
        .ex_immAddress (ex_immAddress),
        .ex_rd2        (ex_rd2),
        .ex_zero       (ex_zero),
        .ex_rd         (ex_rd),
        .ex_RegWrite   (ex_RegWrite),
        .ex_MemRead    (ex_MemRead),
        .ex_MemWrite   (ex_MemWrite),
        .ex_MemtoReg   (ex_MemtoReg),
        .ex_Branch     (ex_Branch),
        .ex_funct3     (ex_funct3),
        .mem_valid     (mem_valid),
        .mem_ALUOut    (mem_ALUOut),
        .mem_rd2       (mem_rd2),
        .mem_rd        (mem_rd),
        .mem_RegWrite  (mem_RegWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemtoReg  (mem_MemtoReg),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .taken_count   (taken_count)
    );

    typedef struct packed {
        logic         rst, stall, valid, branch, zero;
        logic [2:0]   f3;
        logic [W-1:0] alu, imm, rd2;
        logic [4:0]   rd;
        logic         rw, mr, mw, mtr;
    } stim_t;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] alu, rd2;
        logic [4:0]   rd;
        logic         rw, mr, mw, mtr, pc;
        logic [W-1:0] bt;
        logic [31:0]  cnt;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   m;
    logic   m_redirect;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic step(input stim_t s);
        exp_t e;
        logic taken;
        @(negedge clk);
        rst = s.rst; stall = s.stall; ex_valid = s.valid; ex_Branch = s.branch;
        ex_zero = s.zero; ex_funct3 = s.f3; ex_ALUOut = s.alu; ex_immAddress = s.imm;
        ex_rd2 = s.rd2; ex_rd = s.rd; ex_RegWrite = s.rw; ex_MemRead = s.mr;
        ex_MemWrite = s.mw; ex_MemtoReg = s.mtr;

        taken = s.valid && s.branch &&
                ((s.f3 == 3'b000 && s.zero) || (s.f3 == 3'b001 && !s.zero));
        if (s.rst) begin
            m = '0;
            m_redirect = 1'b0;
        end else if (!s.stall) begin
            m.alu = s.alu; m.rd2 = s.rd2; m.rd = s.rd; m.mtr = s.mtr;
            if (m_redirect) begin
                m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
                m.pc = 1'b0;
                m_redirect = 1'b0;
            end else begin
                m.valid = s.valid;
                m.rw = s.rw && s.valid; m.mr = s.mr && s.valid; m.mw = s.mw && s.valid;
                m.pc = taken;
                if (taken) begin
                    m.bt = s.imm;
                    m.cnt = m.cnt + 32'd1;
                    m_redirect = 1'b1;
                end
            end
        end
        sb_q.push_back(m);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("mem_valid",     64'(mem_valid),     64'(e.valid));
        check("mem_ALUOut",    64'(mem_ALUOut),    64'(e.alu));
        check("mem_rd2",       64'(mem_rd2),       64'(e.rd2));
        check("mem_rd",        64'(mem_rd),        64'(e.rd));
        check("mem_RegWrite",  64'(mem_RegWrite),  64'(e.rw));
        check("mem_MemRead",   64'(mem_MemRead),   64'(e.mr));
        check("mem_MemWrite",  64'(mem_MemWrite),  64'(e.mw));
        check("mem_MemtoReg",  64'(mem_MemtoReg),  64'(e.mtr));
        check("pc_src",        64'(pc_src),        64'(e.pc));
        check("flush_if_id",   64'(flush_if_id),   64'(e.pc));
        check("flush_id_ex",   64'(flush_id_ex),   64'(e.pc));
        check("branch_target", 64'(branch_target), 64'(e.bt));
        check("taken_count",   64'(taken_count),   64'(e.cnt));
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t br(input logic [2:0] f3, input logic zero, input logic [W-1:0] imm);
        stim_t s;
        s = '0;
        s.valid = 1'b1; s.branch = 1'b1; s.f3 = f3; s.zero = zero; s.imm = imm;
        s.alu = 32'h0000_00AA; s.rd2 = 32'h0000_0BB0;
        return s;
    endfunction

    initial begin
        stim_t s;
        m = '0;
        m_redirect = 1'b0;

        // Reset state
        s = nop(); s.rst = 1'b1;
        step(s);
        step(s);
        check("rst_pc_src", 64'(pc_src), 64'd0);
        check("rst_count",  64'(taken_count), 64'd0);

        // BEQ taken to 0x40, redirect lasts one cycle
        step(br(3'b000, 1'b1, 32'h0000_0040));
        check("beq_pc_src", 64'(pc_src), 64'd1);
        check("beq_target", 64'(branch_target), 64'h40);
        check("beq_flush",  64'({flush_if_id, flush_id_ex}), 64'd3);
        check("beq_count",  64'(taken_count), 64'd1);
        step(nop());
        check("beq_pc_drop", 64'(pc_src), 64'd0);

        // BNE with zero set: not taken, plain capture
        s = br(3'b001, 1'b1, 32'h0000_0080); s.alu = 32'h1234_5678; s.rd = 5'd7; s.rw = 1'b1;
        step(s);
        check("bne_nt_pc",    64'(pc_src), 64'd0);
        check("bne_nt_alu",   64'(mem_ALUOut), 64'h1234_5678);
        check("bne_nt_valid", 64'(mem_valid), 64'd1);

        // Taken BNE followed by a store: the store is squashed
        step(br(3'b001, 1'b0, 32'h0000_0100));
        s = nop(); s.valid = 1'b1; s.mw = 1'b1; s.rd2 = 32'hCAFE_0001; s.alu = 32'h0000_2000;
        step(s);
        check("squash_valid", 64'(mem_valid), 64'd0);
        check("squash_mw",    64'(mem_MemWrite), 64'd0);

        // Taken branch then three stalled cycles: redirect held
        step(br(3'b000, 1'b1, 32'h0000_0200));
        for (int i = 0; i < 3; i++) begin
            s = br(3'b000, 1'b1, 32'h0000_0300); s.stall = 1'b1; s.alu = 32'h5555_0000 + W'(i);
            step(s);
            check("stall_pc_hold", 64'(pc_src), 64'd1);
        end
        step(nop());

        // Back-to-back taken branches: second is squashed
        step(br(3'b000, 1'b1, 32'h0000_0400));
        step(br(3'b000, 1'b1, 32'h0000_0500));
        check("b2b_pc", 64'(pc_src), 64'd0);
        check("b2b_target", 64'(branch_target), 64'h400);

        // Unsupported funct3 never taken; invalid instruction clears controls
        step(br(3'b100, 1'b1, 32'h0000_0600));
        s = nop(); s.rw = 1'b1; s.mr = 1'b1; s.mw = 1'b1; s.mtr = 1'b1; s.rd = 5'd31;
        step(s);
        check("inv_ctrl", 64'({mem_RegWrite, mem_MemRead, mem_MemWrite}), 64'd0);

        // Reset with stall while redirecting
        step(br(3'b001, 1'b0, 32'h0000_0700));
        s = br(3'b000, 1'b1, 32'h0000_0800); s.rst = 1'b1; s.stall = 1'b1;
        step(s);
        check("rst_redir_pc", 64'(pc_src), 64'd0);
        check("rst_redir_cnt", 64'(taken_count), 64'd0);
        step(nop());

        // Counter wrap from all ones
        @(negedge clk);
        force u_dut.r_taken_count = 32'hFFFF_FFFF;
        #1;
        release u_dut.r_taken_count;
        m.cnt = 32'hFFFF_FFFF;
        step(br(3'b000, 1'b1, 32'h0000_0900));
        check("wrap_count", 64'(taken_count), 64'd0);
        step(nop());

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            s.rst    = ($urandom_range(0, 40) == 0);
            s.stall  = ($urandom_range(0, 3) == 0);
            s.valid  = ($urandom_range(0, 4) != 0);
            s.branch = $urandom_range(0, 1) != 0;
            s.zero   = $urandom_range(0, 1) != 0;
            s.f3     = 3'($urandom_range(0, 3));
            s.alu    = $urandom;
            s.imm    = $urandom;
            s.rd2    = $urandom;
            s.rd     = 5'($urandom_range(0, 31));
            s.rw     = $urandom_range(0, 1) != 0;
            s.mr     = $urandom_range(0, 1) != 0;
            s.mw     = $urandom_range(0, 1) != 0;
            s.mtr    = $urandom_range(0, 1) != 0;
            step(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
